regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-read-port register file with write-to-read bypass and a per-register busy scoreboard.
- Successor to the fixed 32x64, 2-read/1-write register file.
- Sits between decode and execute/writeback in the pipelined core.
- Serves operand reads, accepts one writeback per cycle, and tracks registers with in-flight producers so decode can stall on hazards.

Parameters:
DATA_W, 64, register width in bits
DEPTH, 32, number of registers (power of two, >=2); AW = $clog2(DEPTH)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy
RD_REG, 0, 0 = combinational read; 1 = read data registered (1-cycle latency)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  reset, synchronous, active-low
rd_addr  input  NUM_RD*AW  packed read addresses, port p at [p*AW +: AW]
rd_data  output  NUM_RD*DATA_W  packed read data, port p at [p*DATA_W +: DATA_W]
rd_busy  output  NUM_RD  busy bit of addressed register, per port
wr_en  input  1  writeback enable
wr_addr  input  AW  writeback address
wr_data  input  DATA_W  writeback data
iss_en  input  1  issue: mark iss_addr busy (producer in flight)
iss_addr  input  AW  issue destination address
busy_vec  output  DEPTH  full scoreboard, bit i = register i busy

Behaviour:
Reset:
- Sampled at posedge with rst==0: all registers <= 0, busy_vec <= 0.
- With RD_REG=1, rd_data <= 0 and rd_busy <= 0.
- wr_en/iss_en are ignored in a reset cycle.
- Reset mid-operation discards in-flight busy marks.

Write:
- At posedge with wr_en=1, reg[wr_addr] <= wr_data.
- ZERO_REG=1 and wr_addr=0: the write is dropped.

Read, RD_REG=0:
- rd_data[p] is combinational from reg[rd_addr[p]].
- Bypass: if wr_en=1 and wr_addr==rd_addr[p] (and not the zero register), rd_data[p] = wr_data in the same cycle.
- ZERO_REG=1 and rd_addr[p]=0: rd_data[p] = 0 always, including under bypass.

Read, RD_REG=1:
- rd_data[p] and rd_busy[p] are registered.
- The value sampled at posedge T is the post-write value of cycle T; the same-cycle write is bypassed into the output register.
- Output is valid from T+1 onward.

Scoreboard:
- At posedge, iss_en=1 sets busy[iss_addr]; wr_en=1 clears busy[wr_addr].
- Same address, both events in the same cycle: the set wins; busy stays 1 (new producer issued as old one retires).
- Different addresses: both take effect.
- ZERO_REG=1: busy[0] is forced to 0.
- Re-issue to an already-busy register leaves it 1. There is no producer count; one writeback clears it.

rd_busy:
- rd_busy[p] = busy[rd_addr[p]] after the same-cycle writeback clear is applied, ignoring same-cycle issue.
- Net effect: a result written back this cycle is readable and not busy.
- Same registered/combinational timing as rd_data.

Read ports are independent. Identical addresses on multiple ports return identical data.

No X on any output after the first reset, for any address value.

Test Plan:
1. Reset (rst=0 for 2 cycles) then read all addresses on both ports -> rd_data=0, rd_busy=0, busy_vec=0.
2. Write reg 5=0x1234 at T; RD_REG=0, rd_addr[0]=5 during T -> rd_data[0]=0x1234 (bypass) in T and thereafter. RD_REG=1 -> 0x1234 from T+1.
3. ZERO_REG=1: wr_en, wr_addr=0, wr_data=0xFFFF; iss_en, iss_addr=0 -> reads of reg 0 return 0 and busy_vec[0]=0, including the bypass cycle.
4. iss_en addr 7 at T -> busy_vec[7]=1 from T+1. At T+3, wr_en addr 7 data 0xAB plus iss_en addr 7 -> busy stays 1 and reg7=0xAB. At T+4, wr_en addr 7 only -> busy_vec[7]=0 from T+5.
5. Assert rst with busy_vec=0x0000_00F0 and reg3=0x55 -> next cycle busy_vec=0, reg3 reads 0, and a simultaneous wr_en in the reset cycle is ignored.
6. Randomised run, NUM_RD=4, 10k cycles, against a reference model of registers plus busy bits -> zero mismatches. Compare with case equality.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Register file bus: operand read ports, writeback, issue and scoreboard view.
// Port p of the packed read vectors sits at [p*AW +: AW] / [p*DATA_W +: DATA_W].
interface regfile_mp_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int AW     = $clog2(DEPTH)
);
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [AW-1:0]            iss_addr;
    logic [DEPTH-1:0]         busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-to-read bypass and a busy scoreboard
// that decode uses to stall on in-flight producers.
module regfile_mp #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int RD_REG   = 0
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);
    localparam int AW       = $clog2(DEPTH);
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [DATA_W-1:0]        regs [DEPTH];
    logic [DEPTH-1:0]         busy;
    logic [DEPTH-1:0]         wr_mask;
    logic [DEPTH-1:0]         iss_mask;
    logic [DEPTH-1:0]         busy_clr;
    logic [DEPTH-1:0]         busy_next;
    logic                     wr_ok;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [NUM_RD-1:0]        rd_busy_c;

    // Writes to the zero register and writes during reset never happen, so they
    // must not bypass into reads or clear busy bits either.
    assign wr_ok = rst && bus.wr_en && !(HAS_ZERO && (bus.wr_addr == '0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Retirement clears first, then issue sets, so a same-address issue wins.
    always_comb begin
        wr_mask  = '0;
        iss_mask = '0;
        if (wr_ok) begin
            wr_mask[bus.wr_addr] = 1'b1;
        end
        if (bus.iss_en) begin
            iss_mask[bus.iss_addr] = 1'b1;
        end
        busy_clr  = busy & ~wr_mask;
        busy_next = busy_clr | iss_mask;
        if (HAS_ZERO) begin
            busy_clr[0]  = 1'b0;
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign bus.busy_vec = busy;

    // Read busy sees this cycle's retirement but not this cycle's issue.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic [AW-1:0] addr;
        logic          zero_hit;
        logic          bypass;

        assign addr     = bus.rd_addr[p*AW +: AW];
        assign zero_hit = HAS_ZERO && (addr == '0);
        assign bypass   = wr_ok && (bus.wr_addr == addr);

        assign rd_data_c[p*DATA_W +: DATA_W] = zero_hit ? '0 :
                                               bypass   ? bus.wr_data :
                                                          regs[addr];
        assign rd_busy_c[p] = busy_clr[addr];
    end

    if (RD_REG != 0) begin : g_rd_reg
        logic [NUM_RD*DATA_W-1:0] rd_data_q;
        logic [NUM_RD-1:0]        rd_busy_q;

        always_ff @(posedge clk) begin
            if (!rst) begin
                rd_data_q <= '0;
                rd_busy_q <= '0;
            end else begin
                rd_data_q <= rd_data_c;
                rd_busy_q <= rd_busy_c;
            end
        end

        assign bus.rd_data = rd_data_q;
        assign bus.rd_busy = rd_busy_q;
    end else begin : g_rd_comb
        assign bus.rd_data = rd_data_c;
        assign bus.rd_busy = rd_busy_c;
    end
endmodule
